uart_rx: RTL
============

Name: uart_rx

Overview:
UART receiver, the receive-side counterpart of the team's UART transmitter: same frame format, same parity controls.
- Frame: start bit (0), DATA_WIDTH data bits LSB first, optional parity bit, one stop bit (1).
- Oversamples the serial line at Prescale clocks per bit and takes a 2-of-3 majority vote at mid-bit.
- Delivers the parallel word with a one-cycle valid strobe, plus parity and stop error pulses.

Parameters:
DATA_WIDTH, 8, number of data bits per frame.

Ports:
CLK  input  1  system clock; all logic on the rising edge.
RST  input  1  reset, synchronous, active-high.
RX_IN  input  1  serial line; idles high; already synchronised to CLK.
Prescale  input  6  oversampling ratio; legal values 8, 16, 32.
PAR_EN  input  1  1 = frame carries a parity bit.
PAR_TYP  input  1  0 = even parity, 1 = odd parity.
P_DATA  output  DATA_WIDTH  last correctly received word.
Data_valid  output  1  one-cycle strobe; P_DATA updated this cycle.
par_err  output  1  one-cycle pulse at end of frame; parity mismatch.
stp_err  output  1  one-cycle pulse at end of frame; stop bit sampled 0.
busy  output  1  high from start detection to end of stop bit.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, all counters 0. Reset asserted mid-frame aborts the frame; IDLE and zeroed outputs on the next edge; no strobes are issued.
- Config latch: Prescale, PAR_EN and PAR_TYP are latched on the start-detect cycle. Changes mid-frame have no effect.
- Illegal Prescale (not 8/16/32) at detect time: stay in IDLE and ignore RX_IN.
- Counters:
  - edge_cnt counts 0..P-1 within each bit.
  - The detect cycle is edge 0 of the start bit.
  - At edge P-1, edge_cnt wraps to 0 and the bit ends.
  - bit_cnt counts data bits 0..DATA_WIDTH-1.
- Sampling: RX_IN is sampled at edges P/2-1, P/2 and P/2+1. Bit value = majority (≥2 of 3). The decision is used at edge P-1.
- States and transitions:
  - IDLE: busy=0. RX_IN==0 -> START.
  - START: at edge P-1, voted 0 -> DATA; voted 1 (glitch) -> IDLE silently, no error pulse.
  - DATA: at each edge P-1, shift the voted bit into the shift register at position bit_cnt (LSB first). After bit DATA_WIDTH-1: PAR_EN=1 -> PARITY, else -> STOP.
  - PARITY: at edge P-1, store the voted bit -> STOP.
  - STOP: at edge P-1 -> IDLE and evaluate the frame.
- Frame evaluation (registered, visible in the cycle after stop edge P-1):
  - perr = PAR_EN & (parity bit != (XOR of data) ^ PAR_TYP).
  - serr = (stop vote == 0).
  - Data_valid = !perr & !serr.
  - par_err = perr; stp_err = serr.
  - P_DATA is loaded only when Data_valid=1; otherwise it holds its previous value.
  - All three strobes are exactly one cycle wide.
- Latency: strobes appear in cycle N·P counted from the detect cycle (cycle 0), where N = 2 + DATA_WIDTH + PAR_EN.
- Back-to-back frames: RX_IN==0 in the strobe cycle is a valid new start detect (FSM already in IDLE). The strobes are not disturbed by it.
- busy: 1 in START/DATA/PARITY/STOP, 0 in IDLE and in the strobe cycle.

Decomposition:
- Package uart_pkg:
  - RX state encoding (one-hot, 5 bits: IDLE, START, DATA, PARITY, STOP).
  - Legal prescale constants 8/16/32.
  - Parity type constants EVEN=0, ODD=1.
- Sub-module uart_rx_sampler: edge counter plus 3-sample majority voter. Outputs edge_cnt, bit_end and sampled_bit; enabled by the FSM.
- FSM, shift register, bit counter and error/strobe logic live in uart_rx.

Test Plan:
1. Prescale=8, PAR_EN=1, PAR_TYP=0, frame 0xA5 with parity 0 and stop 1 -> Data_valid=1 in cycle 88 only, P_DATA=0xA5, par_err=stp_err=0, busy high cycles 0..87.
2. Prescale=8, PAR_EN=1, PAR_TYP=0, data 0x3C with parity bit 1 -> par_err pulse in cycle 88, Data_valid=0, P_DATA keeps 0xA5.
3. Prescale=16, PAR_EN=0, data 0x5A with stop bit 0 -> stp_err pulse in cycle 160, Data_valid=0.
4. Prescale=16, RX_IN low for 3 cycles then high -> FSM returns to IDLE after edge 15, busy low from cycle 16, no strobes.
5. Prescale=32, PAR_EN=0, back-to-back 0x00 then 0xFF with a single-cycle inverted glitch at edge P/2 of every bit -> two Data_valid strobes at cycles 320 and 640, P_DATA=0x00 then 0xFF.
6. RST high for one cycle during data bit 4 -> all outputs 0 next cycle, no strobe; a following clean 0x81 frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: state encoding, legal
// oversampling ratios and parity-type constants.
package uart_pkg;

    typedef enum logic [4:0] {
        RX_IDLE   = 5'b00001,
        RX_START  = 5'b00010,
        RX_DATA   = 5'b00100,
        RX_PARITY = 5'b01000,
        RX_STOP   = 5'b10000
    } rx_state_t;

    localparam logic [5:0] PRESCALE_8  = 6'd8;
    localparam logic [5:0] PRESCALE_16 = 6'd16;
    localparam logic [5:0] PRESCALE_32 = 6'd32;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    function automatic logic is_legal_prescale(input logic [5:0] p);
        return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter and 2-of-3 mid-bit majority voter for the UART receiver.
module uart_rx_sampler (
    input  logic       CLK,
    input  logic       RST,
    input  logic       i_en,
    input  logic       i_rx,
    input  logic [5:0] i_prescale,
    output logic [5:0] o_edge_cnt,
    output logic       o_bit_end,
    output logic       o_sampled_bit
);

    logic [5:0] r_edge_cnt;
    logic [2:0] r_samples;
    logic [5:0] w_last;
    logic [5:0] w_mid;

    assign w_last = i_prescale - 6'd1;
    assign w_mid  = {1'b0, i_prescale[5:1]};

    assign o_edge_cnt    = r_edge_cnt;
    assign o_bit_end     = i_en && (r_edge_cnt == w_last);
    assign o_sampled_bit = (r_samples[0] & r_samples[1]) |
                           (r_samples[0] & r_samples[2]) |
                           (r_samples[1] & r_samples[2]);

    // NOTE: non-blocking assignments for every register so all flops update from pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_edge_cnt <= '0;
            r_samples  <= '0;
        end else if (!i_en) begin
            r_edge_cnt <= '0;
        end else begin
            r_edge_cnt <= o_bit_end ? 6'd0 : r_edge_cnt + 6'd1;
            if (r_edge_cnt == w_mid - 6'd1) r_samples[0] <= i_rx;
            if (r_edge_cnt == w_mid)        r_samples[1] <= i_rx;
            if (r_edge_cnt == w_mid + 6'd1) r_samples[2] <= i_rx;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start/data/parity/stop framing with configurable oversampling,
// registered end-of-frame evaluation producing valid, parity and stop strobes.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [5:0]            Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  busy
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    rx_state_t             r_state, w_next_state;
    logic [5:0]            r_prescale;
    logic                  r_par_en, r_par_typ, r_par_bit;
    logic [DATA_WIDTH-1:0] r_shift, r_p_data;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic                  r_data_valid, r_par_err, r_stp_err;

    logic       w_detect, w_en, w_bit_end, w_bit, w_last_bit;
    logic       w_exp_par, w_perr, w_serr, w_valid;
    logic [5:0] w_prescale, w_edge_cnt;

    // The edge counter is always parked at zero in IDLE; requiring it keeps a
    // detect from ever overlapping a bit that is still being timed.
    assign w_detect   = (r_state == RX_IDLE) && !RX_IN && (w_edge_cnt == 6'd0) &&
                        is_legal_prescale(Prescale);
    assign w_en       = w_detect || (r_state != RX_IDLE);
    assign w_prescale = (r_state == RX_IDLE) ? Prescale : r_prescale;
    assign w_last_bit = (r_bit_cnt == CNT_W'(DATA_WIDTH - 1));

    uart_rx_sampler u_sampler (
        .CLK          (CLK),
        .RST          (RST),
        .i_en         (w_en),
        .i_rx         (RX_IN),
        .i_prescale   (w_prescale),
        .o_edge_cnt   (w_edge_cnt),
        .o_bit_end    (w_bit_end),
        .o_sampled_bit(w_bit)
    );

    assign w_exp_par = (^r_shift) ^ (r_par_typ == PAR_ODD);
    assign w_perr    = r_par_en & (r_par_bit != w_exp_par);
    assign w_serr    = ~w_bit;
    assign w_valid   = ~w_perr & ~w_serr;

    always_ff @(posedge CLK) begin
        if (RST) r_state <= RX_IDLE;
        else     r_state <= w_next_state;
    end

    // NOTE: next state defaults to the current state first, so no path leaves it unassigned (no latch).
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            RX_IDLE:   if (w_detect) w_next_state = RX_START;
            RX_START:  if (w_bit_end) w_next_state = w_bit ? RX_IDLE : RX_DATA;
            RX_DATA:   if (w_bit_end && w_last_bit)
                           w_next_state = r_par_en ? RX_PARITY : RX_STOP;
            RX_PARITY: if (w_bit_end) w_next_state = RX_STOP;
            RX_STOP:   if (w_bit_end) w_next_state = RX_IDLE;
            default:   w_next_state = RX_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_prescale   <= '0;
            r_par_en     <= 1'b0;
            r_par_typ    <= 1'b0;
            r_par_bit    <= 1'b0;
            r_shift      <= '0;
            r_p_data     <= '0;
            r_bit_cnt    <= '0;
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_stp_err    <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_stp_err    <= 1'b0;
            if (w_detect) begin
                r_prescale <= Prescale;
                r_par_en   <= PAR_EN;
                r_par_typ  <= PAR_TYP;
                r_bit_cnt  <= '0;
            end
            if (w_bit_end) begin
                case (r_state)
                    RX_DATA: begin
                        r_shift[r_bit_cnt] <= w_bit;
                        r_bit_cnt          <= r_bit_cnt + 1'b1;
                    end
                    RX_PARITY: r_par_bit <= w_bit;
                    RX_STOP: begin
                        r_data_valid <= w_valid;
                        r_par_err    <= w_perr;
                        r_stp_err    <= w_serr;
                        if (w_valid) r_p_data <= r_shift;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign P_DATA     = r_p_data;
    assign Data_valid = r_data_valid;
    assign par_err    = r_par_err;
    assign stp_err    = r_stp_err;
    assign busy       = w_en;

endmodule
